// File: rtl/ibex_pin_bus_pkg.sv
// Shared types for the Ibex pin-limited memory link.
// State/source enums, header field positions, header helper.
package ibex_pin_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StAddr,
    StWdata,
    StRdata,
    StResp
  } state_e;

  typedef enum logic {
    SrcInstr = 1'b0,
    SrcData  = 1'b1
  } src_e;

  localparam int unsigned HdrWeBit     = 7;
  localparam int unsigned HdrSrcBit    = 6;
  localparam int unsigned BeatsPerWord = 4;

  function automatic logic [7:0] hdr_byte(
    input logic       we,
    input src_e       src,
    input logic [3:0] be
  );
    logic [7:0] h;
    h            = '0;
    h[HdrWeBit]  = we;
    h[HdrSrcBit] = src;
    h[3:0]       = be;
    return h;
  endfunction

endpackage

// File: rtl/ibex_pin_bus_arb_rr.sv
// Source select: data first, instr after StarveLimit data grants.
// Ports: en_i (arbiter idle), req inputs, one-hot gnt_o.
module ibex_pin_bus_rr
  import ibex_pin_bus_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       instr_req_i,
  input  logic       data_req_i,
  output logic [1:0] gnt_o
);

  localparam int unsigned CntW = $clog2(StarveLimit + 2);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t Limit = cnt_t'(StarveLimit);

  cnt_t cnt_q, cnt_d;
  logic starved;

  always_comb begin
    starved = (cnt_q == Limit) && instr_req_i;
    gnt_o   = 2'b00;
    if (en_i) begin
      if (data_req_i && !starved) begin
        gnt_o[SrcData] = 1'b1;
      end else if (instr_req_i) begin
        gnt_o[SrcInstr] = 1'b1;
      end
    end

    // Count only data grants that made a waiting fetch wait longer.
    cnt_d = cnt_q;
    if (gnt_o[SrcInstr]) begin
      cnt_d = '0;
    end else if (gnt_o[SrcData]) begin
      if (!instr_req_i) begin
        cnt_d = '0;
      end else if (cnt_q != Limit) begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_pin_bus_arb.sv
// Serializes Ibex instr/data accesses onto a byte-wide pad link.
// Ports: Ibex instr/data req-gnt-rvalid, pad out/in streams, busy.
module ibex_pin_bus_arb
  import ibex_pin_bus_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        pad_out_valid_o,
  input  logic        pad_out_ready_i,
  output logic [7:0]  pad_out_data_o,
  input  logic        pad_in_valid_i,
  input  logic [7:0]  pad_in_data_i,
  input  logic        pad_in_err_i,
  output logic        busy_o
);

  localparam logic [1:0] LastBeat = 2'(BeatsPerWord - 1);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        oval_q, oval_d;
  logic [7:0]  odat_q, odat_d;

  logic [1:0]  gnt;
  logic        idle;
  logic        hs;
  logic        last;

  assign idle = (state_q == StIdle);
  assign hs   = oval_q & pad_out_ready_i;
  assign last = (cnt_q == LastBeat);

  ibex_pin_bus_rr #(
    .StarveLimit (StarveLimit)
  ) u_rr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (idle),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .gnt_o       (gnt)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    oval_d  = oval_q;
    odat_d  = odat_q;

    unique case (state_q)
      StIdle: begin
        if (gnt[SrcData]) begin
          src_d   = SrcData;
          we_d    = data_we_i;
          be_d    = data_be_i;
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
        end else if (gnt[SrcInstr]) begin
          src_d   = SrcInstr;
          we_d    = 1'b0;
          be_d    = 4'hF;
          addr_d  = instr_addr_i;
          wdata_d = '0;
        end
        if (|gnt) begin
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          oval_d  = 1'b1;
          odat_d  = hdr_byte(we_d, src_d, be_d);
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (hs) begin
          odat_d  = addr_q[7:0];
          cnt_d   = '0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (hs) begin
          if (last) begin
            cnt_d = '0;
            if (we_q) begin
              odat_d  = wdata_q[7:0];
              state_d = StWdata;
            end else begin
              oval_d  = 1'b0;
              odat_d  = '0;
              state_d = StRdata;
            end
          end else begin
            cnt_d  = cnt_q + 2'd1;
            odat_d = addr_q[{cnt_d, 3'b000} +: 8];
          end
        end
      end
      StWdata: begin
        if (hs) begin
          if (last) begin
            cnt_d   = '0;
            oval_d  = 1'b0;
            odat_d  = '0;
            state_d = StResp;
          end else begin
            cnt_d  = cnt_q + 2'd1;
            odat_d = wdata_q[{cnt_d, 3'b000} +: 8];
          end
        end
      end
      StRdata: begin
        if (pad_in_valid_i) begin
          // LSB arrives first, so shift down from the top.
          rdata_d = {pad_in_data_i, rdata_q[31:8]};
          err_d   = err_q | pad_in_err_i;
          if (last) begin
            cnt_d   = '0;
            state_d = StResp;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= SrcInstr;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      oval_q  <= 1'b0;
      odat_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      oval_q  <= oval_d;
      odat_q  <= odat_d;
    end
  end

  assign instr_gnt_o     = gnt[SrcInstr];
  assign data_gnt_o      = gnt[SrcData];
  assign instr_rvalid_o  = (state_q == StResp) && (src_q == SrcInstr);
  assign data_rvalid_o   = (state_q == StResp) && (src_q == SrcData);
  assign instr_rdata_o   = instr_rvalid_o ? rdata_q : '0;
  assign data_rdata_o    = data_rvalid_o ? rdata_q : '0;
  assign instr_err_o     = instr_rvalid_o & err_q;
  assign data_err_o      = data_rvalid_o & err_q;
  assign pad_out_valid_o = oval_q;
  assign pad_out_data_o  = odat_q;
  assign busy_o          = !idle;

endmodule

// File: tb/tb_ibex_pin_bus_arb.sv
// Bench for ibex_pin_bus_arb: pad device model plus scoreboard.
// Scenarios: reset, reads, writes, starvation, stalls, error, abort.
module tb_ibex_pin_bus_arb;

  typedef struct {
    bit          src;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        instr_req_i = 1'b0;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i = '0;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        pad_out_valid_o;
  logic        pad_out_ready_i = 1'b0;
  logic [7:0]  pad_out_data_o;
  logic        pad_in_valid_i = 1'b0;
  logic [7:0]  pad_in_data_i = '0;
  logic        pad_in_err_i = 1'b0;
  logic        busy_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] exp_out_q[$];
  resp_t      exp_resp_q[$];

  logic [31:0] dev_word = '0;
  int          dev_err_idx = 4;
  int          ready_mode = 0;

  int last_gnt_cyc = 0;
  int last_rv_cyc = 0;
  int resp_cnt = 0;
  int beat_cnt = 0;
  int rd_req_cnt = 0;

  always #5 clk = ~clk;

  ibex_pin_bus_arb #(
    .StarveLimit (4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .instr_req_i     (instr_req_i),
    .instr_gnt_o     (instr_gnt_o),
    .instr_rvalid_o  (instr_rvalid_o),
    .instr_addr_i    (instr_addr_i),
    .instr_rdata_o   (instr_rdata_o),
    .instr_err_o     (instr_err_o),
    .data_req_i      (data_req_i),
    .data_gnt_o      (data_gnt_o),
    .data_rvalid_o   (data_rvalid_o),
    .data_we_i       (data_we_i),
    .data_be_i       (data_be_i),
    .data_addr_i     (data_addr_i),
    .data_wdata_i    (data_wdata_i),
    .data_rdata_o    (data_rdata_o),
    .data_err_o      (data_err_o),
    .pad_out_valid_o (pad_out_valid_o),
    .pad_out_ready_i (pad_out_ready_i),
    .pad_out_data_o  (pad_out_data_o),
    .pad_in_valid_i  (pad_in_valid_i),
    .pad_in_data_i   (pad_in_data_i),
    .pad_in_err_i    (pad_in_err_i),
    .busy_o          (busy_o)
  );

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Pushes expectations on grants, checks beats and responses.
  task automatic monitor();
    int          dev_beat = 0;
    logic        dev_we = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [7:0]  b;
    logic [31:0] got_rd;
    bit          got_err;
    bit          rd_err;
    resp_t       r;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        exp_out_q.delete();
        exp_resp_q.delete();
        dev_beat   = 0;
        prev_stall = 1'b0;
      end else begin
        rd_err = (dev_err_idx < 4);
        if (instr_gnt_o || data_gnt_o) begin
          tests++;
          if (instr_gnt_o && data_gnt_o) begin
            fails++;
            $display("FAIL both_gnt got 11 required one-hot");
          end
          last_gnt_cyc = cyc;
        end
        if (data_gnt_o) begin
          exp_out_q.push_back({data_we_i, 1'b1, 2'b00, data_be_i});
          for (int i = 0; i < 4; i++)
            exp_out_q.push_back(data_addr_i[8*i +: 8]);
          if (data_we_i) begin
            for (int i = 0; i < 4; i++)
              exp_out_q.push_back(data_wdata_i[8*i +: 8]);
            exp_resp_q.push_back('{1'b1, 32'h0, 1'b0});
          end else begin
            exp_resp_q.push_back('{1'b1, dev_word, rd_err});
          end
        end else if (instr_gnt_o) begin
          exp_out_q.push_back(8'h0F);
          for (int i = 0; i < 4; i++)
            exp_out_q.push_back(instr_addr_i[8*i +: 8]);
          exp_resp_q.push_back('{1'b0, dev_word, rd_err});
        end
        if (prev_stall) begin
          tests++;
          if (!pad_out_valid_o || pad_out_data_o !== prev_data) begin
            fails++;
            $display("FAIL stall_hold got v=%0b d=%02h required v=1 d=%02h",
                     pad_out_valid_o, pad_out_data_o, prev_data);
          end
        end
        if (pad_out_valid_o && pad_out_ready_i) begin
          tests++;
          beat_cnt++;
          if (exp_out_q.size() == 0) begin
            fails++;
            $display("FAIL extra_beat got %02h required none",
                     pad_out_data_o);
          end else begin
            b = exp_out_q.pop_front();
            if (pad_out_data_o !== b) begin
              fails++;
              $display("FAIL out_beat got %02h required %02h",
                       pad_out_data_o, b);
            end
          end
          if (dev_beat == 0) dev_we = pad_out_data_o[7];
          dev_beat++;
          if (!dev_we && dev_beat == 5) begin
            rd_req_cnt++;
            dev_beat = 0;
          end else if (dev_we && dev_beat == 9) begin
            dev_beat = 0;
          end
        end
        prev_stall = pad_out_valid_o && !pad_out_ready_i;
        prev_data  = pad_out_data_o;
        if (instr_rvalid_o || data_rvalid_o) begin
          tests++;
          resp_cnt++;
          last_rv_cyc = cyc;
          got_rd  = data_rvalid_o ? data_rdata_o : instr_rdata_o;
          got_err = data_rvalid_o ? data_err_o : instr_err_o;
          if (instr_rvalid_o && data_rvalid_o) begin
            fails++;
            $display("FAIL both_rvalid got 11 required one-hot");
          end else if (exp_resp_q.size() == 0) begin
            fails++;
            $display("FAIL extra_rvalid got src=%0b required none",
                     data_rvalid_o);
          end else begin
            r = exp_resp_q.pop_front();
            if (data_rvalid_o !== r.src || got_rd !== r.rdata ||
                got_err !== r.err) begin
              fails++;
              $display("FAIL resp got src=%0b rd=%08h err=%0b required src=%0b rd=%08h err=%0b",
                       data_rvalid_o, got_rd, got_err,
                       r.src, r.rdata, r.err);
            end
          end
        end
      end
    end
  endtask

  // Drives ready and returns read bytes right after the address.
  task automatic device();
    int pend = 0;
    int ack = 0;
    int idx;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_ni) begin
        pend = 0;
        ack  = rd_req_cnt;
        pad_in_valid_i  = 1'b0;
        pad_in_data_i   = '0;
        pad_in_err_i    = 1'b0;
        pad_out_ready_i = 1'b0;
      end else begin
        if (ready_mode == 0)
          pad_out_ready_i = 1'b1;
        else
          pad_out_ready_i = ((cyc - last_gnt_cyc - 1) % 3 == 0);
        if (pend == 0 && ack != rd_req_cnt) begin
          ack++;
          pend = 4;
        end
        if (pend > 0) begin
          idx = 4 - pend;
          pad_in_valid_i = 1'b1;
          pad_in_data_i  = dev_word[8*idx +: 8];
          pad_in_err_i   = (idx == dev_err_idx);
          pend--;
        end else begin
          pad_in_valid_i = 1'b0;
          pad_in_data_i  = '0;
          pad_in_err_i   = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access and waits for its response; reports latency.
  task automatic run_access(
    input  bit          is_data,
    input  bit          we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output int          lat,
    output bit          ok
  );
    int r0 = resp_cnt;
    bit g = 1'b0;
    ok  = 1'b0;
    lat = -1;
    if (is_data) begin
      data_we_i    = we;
      data_be_i    = be;
      data_addr_i  = addr;
      data_wdata_i = wdata;
      data_req_i   = 1'b1;
    end else begin
      instr_addr_i = addr;
      instr_req_i  = 1'b1;
    end
    for (int i = 0; i < 50 && !g; i++) begin
      @(negedge clk);
      #1;
      if (is_data ? data_gnt_o : instr_gnt_o) g = 1'b1;
    end
    tick();
    data_req_i  = 1'b0;
    instr_req_i = 1'b0;
    if (g) begin
      for (int i = 0; i < 400 && !ok; i++) begin
        if (resp_cnt > r0) ok = 1'b1;
        else begin
          @(negedge clk);
          #1;
        end
      end
      if (ok) lat = last_rv_cyc - last_gnt_cyc;
    end
  endtask

  task automatic test_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
         data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
         pad_out_valid_o, pad_out_data_o, busy_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got nonzero required all 0");
    end
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_instr_read();
    int lat;
    bit ok;
    dev_word    = 32'h0000_0013;
    dev_err_idx = 4;
    ready_mode  = 0;
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0080, 32'h0, lat, ok);
    tests++;
    if (!ok || lat !== 10) begin
      fails++;
      $display("FAIL instr_read_lat got %0d required 10", lat);
    end
    tick();
    tests++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_busy got %0b required 0", busy_o);
    end
  endtask

  task automatic test_data_write();
    int lat;
    bit ok;
    ready_mode = 0;
    run_access(1'b1, 1'b1, 4'b0010, 32'h1000_0004, 32'hAABB_CCDD, lat, ok);
    tests++;
    if (!ok || lat !== 10) begin
      fails++;
      $display("FAIL data_write_lat got %0d required 10", lat);
    end
    tick();
  endtask

  task automatic test_data_read();
    int lat;
    bit ok;
    dev_word   = 32'h8765_4321;
    ready_mode = 0;
    run_access(1'b1, 1'b0, 4'b1100, 32'h0000_0F00, 32'h0, lat, ok);
    tests++;
    if (!ok || lat !== 10) begin
      fails++;
      $display("FAIL data_read_lat got %0d required 10", lat);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    int n;
    int c;
    int exp_lat;
    ready_mode = 1;
    n = 0;
    c = 0;
    while (n < 9) begin
      c++;
      if ((c - 1) % 3 == 0) n++;
    end
    exp_lat = c + 1;
    run_access(1'b1, 1'b1, 4'hF, 32'h2000_0010, 32'h0102_0304, lat, ok);
    tests++;
    if (!ok || lat !== exp_lat) begin
      fails++;
      $display("FAIL bp_write_lat got %0d required %0d", lat, exp_lat);
    end
    tick();
    dev_word = 32'h5566_7788;
    n = 0;
    c = 0;
    while (n < 5) begin
      c++;
      if ((c - 1) % 3 == 0) n++;
    end
    exp_lat = c + 5;
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0200, 32'h0, lat, ok);
    tests++;
    if (!ok || lat !== exp_lat) begin
      fails++;
      $display("FAIL bp_read_lat got %0d required %0d", lat, exp_lat);
    end
    ready_mode = 0;
    tick();
  endtask

  task automatic test_read_err();
    int lat;
    bit ok;
    dev_word    = 32'hCAFE_F00D;
    dev_err_idx = 1;
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, lat, ok);
    tests++;
    if (!ok || lat !== 10) begin
      fails++;
      $display("FAIL read_err_lat got %0d required 10", lat);
    end
    dev_err_idx = 4;
    tick();
  endtask

  task automatic test_starvation();
    bit exp_d[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit seen;
    bit got;
    int r0 = resp_cnt;
    bit ok = 1'b0;
    dev_word     = 32'h0000_0055;
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h0000_2000;
    data_wdata_i = 32'h1234_5678;
    instr_addr_i = 32'h0000_0400;
    data_req_i   = 1'b1;
    instr_req_i  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      seen = 1'b0;
      got  = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        #1;
        if (instr_gnt_o || data_gnt_o) begin
          seen = 1'b1;
          got  = data_gnt_o;
        end
      end
      tests++;
      if (!seen || got !== exp_d[k]) begin
        fails++;
        $display("FAIL starve_order[%0d] got seen=%0b data=%0b required data=%0b",
                 k, seen, got, exp_d[k]);
      end
    end
    tick();
    data_req_i  = 1'b0;
    instr_req_i = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (resp_cnt >= r0 + 10) ok = 1'b1;
      else tick();
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL starve_resp got %0d required 10", resp_cnt - r0);
    end
    tick();
  endtask

  task automatic test_reset_mid_addr();
    int b0 = beat_cnt;
    int r0;
    int lat;
    bit ok;
    bit g = 1'b0;
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h3000_0008;
    data_wdata_i = 32'h0BAD_BEEF;
    data_req_i   = 1'b1;
    for (int i = 0; i < 20 && !g; i++) begin
      @(negedge clk);
      #1;
      g = data_gnt_o;
    end
    tick();
    data_req_i = 1'b0;
    for (int i = 0; i < 20 && beat_cnt < b0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    tests++;
    if (beat_cnt < b0 + 3 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL abort_setup got beats=%0d busy=%0b required 3 1",
               beat_cnt - b0, busy_o);
    end
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
         data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
         pad_out_valid_o, pad_out_data_o, busy_o} !== '0) begin
      fails++;
      $display("FAIL abort_outputs got nonzero required all 0");
    end
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    r0 = resp_cnt;
    for (int i = 0; i < 15; i++) tick();
    tests++;
    if (resp_cnt !== r0) begin
      fails++;
      $display("FAIL abort_rvalid got %0d required 0", resp_cnt - r0);
    end
    dev_word = 32'h7777_0001;
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, lat, ok);
    tests++;
    if (!ok || lat !== 10) begin
      fails++;
      $display("FAIL post_abort_lat got %0d required 10", lat);
    end
    tick();
  endtask

  initial begin
    fork
      cycle_counter();
      monitor();
      device();
    join_none
    test_reset();
    test_instr_read();
    test_data_write();
    test_data_read();
    test_backpressure();
    test_read_err();
    test_starvation();
    test_reset_mid_addr();
    tests++;
    if (exp_out_q.size() != 0 || exp_resp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover got out=%0d resp=%0d required 0 0",
               exp_out_q.size(), exp_resp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ibex_pin_bus_arb.md
# ibex_pin_bus_arb

Arbitrates the Ibex instruction and data request/grant/rvalid ports onto one narrow, byte-wide, pin-limited off-chip memory link, and sits between `ibex_top` and the chip pads inside the chip top. Each 32-bit access is serialized as a header byte, four address bytes, and either four write-data bytes out or four read-data bytes back. Exactly one transaction is outstanding at a time. Data accesses have priority, and a starvation guard prevents instruction fetch lockout.

## Interface
Parameters:
- `StarveLimit`, default 4: consecutive data grants allowed while an instruction request is pending; the next grant then goes to instr.

Ports:
- `clk_i` in 1: core clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `instr_req_i` in 1 / `instr_gnt_o` out 1 / `instr_rvalid_o` out 1: Ibex instr handshake.
- `instr_addr_i` in 32: fetch address.
- `instr_rdata_o` out 32, `instr_err_o` out 1: fetch response.
- `data_req_i` in 1 / `data_gnt_o` out 1 / `data_rvalid_o` out 1: Ibex data handshake.
- `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32: LSU request.
- `data_rdata_o` out 32, `data_err_o` out 1: LSU response.
- `pad_out_valid_o` out 1 / `pad_out_ready_i` in 1 / `pad_out_data_o` out 8: outbound byte stream; a beat transfers when valid and ready are both high.
- `pad_in_valid_i` in 1, `pad_in_data_i` in 8, `pad_in_err_i` in 1: inbound read bytes; no backpressure.
- `busy_o` out 1: a transaction is in flight (state is not IDLE).

## Operation
- FSM states: IDLE → HDR → ADDR → (WDATA | RDATA) → RESP → IDLE.
- **IDLE:** select a source.
  - Pick data if `data_req_i` is high, unless the starvation count equals `StarveLimit` and `instr_req_i` is high; in that case pick instr.
  - Assert the selected gnt combinationally in the same cycle.
  - Latch addr, we, be and wdata. Instr requests always latch we=0 and be=4'hF.
  - Go to HDR.
- **Starvation counter:**
  - Increments on each data grant made while `instr_req_i` is high.
  - Clears on any instr grant, and on any data grant made while `instr_req_i` is low.
  - Saturates at `StarveLimit`.
- **Header byte:**
  - bit7 = we.
  - bit6 = source (1 = data).
  - bits5:4 = 0.
  - bits3:0 = be.
- **HDR:** drive the header byte; on handshake go to ADDR.
- **ADDR:** four address beats, LSB first, using a 2-bit beat counter. After beat 3: go to WDATA if we=1, else RDATA.
- **WDATA:** four wdata beats, LSB first. After beat 3, go to RESP with err=0.
- **RDATA:**
  - Each `pad_in_valid_i` shifts a byte into rdata, LSB first.
  - err is the OR of `pad_in_err_i` across the four beats.
  - After the 4th byte, go to RESP.
- **RESP:**
  - Pulse rvalid for one cycle, to the latched source only.
  - rdata and err are valid in that cycle. rdata is 0 for writes.
  - Go to IDLE. A new grant is possible in the following cycle, not during RESP.
- **Rules:**
  - gnt is never asserted outside IDLE.
  - Both gnts are never high in the same cycle.
  - `pad_out_valid_o` stays high and `pad_out_data_o` stays stable until ready; the output path is registered.
  - `pad_in_valid_i` outside RDATA is ignored.
- **Reset:** asynchronous, at any point, including mid-serialization.
  - FSM returns to IDLE; counters and latches clear.
  - No rvalid is issued for the aborted access.
  - The external device must be reset alongside the core.

## Timing
- Reset values: all outputs 0, including rdata and err.
- Grant: 0 cycles after req in IDLE, combinational.
- `pad_out_valid_o` rises the cycle after the grant.
- Latency, with ready held high and read bytes returned back-to-back immediately:
  - Write: grant at cycle 0, 9 outbound beats at cycles 1–9, rvalid at cycle 10.
  - Read: grant at cycle 0, 5 outbound beats at cycles 1–5, in-bytes from cycle 6, rvalid at cycle 10.
- Throughput: at most one access per 11 cycles.
- `pad_out_ready_i` low stalls the current beat indefinitely; there is no timeout.
- Arithmetic:
  - Byte selection is `word[8*cnt +: 8]`.
  - The beat counter wraps 3→0 on the state change.

## Structure
- Shared package `ibex_pin_bus_pkg` holds:
  - the state enum type;
  - header field bit positions (`HdrWeBit`=7, `HdrSrcBit`=6);
  - `BeatsPerWord`=4;
  - the source enum (`SrcInstr`, `SrcData`).
- Optional sub-module `ibex_pin_bus_rr`: the selection and starvation-counter logic, with req inputs and a one-hot select output.
- The serializer stays in the top module.

## Test plan
- **Single instr read:** instr_req at 0x0000_0080, ready held high, in-bytes 13,00,00,00 → header 0x0F; addr bytes 80,00,00,00; instr_rvalid for 1 cycle with rdata 0x0000_0013 and err 0.
- **Data byte write:** we=1, be=4'b0010, addr 0x1000_0004, wdata 0xAABB_CCDD → header 0xC2; addr 04,00,00,10; data DD,CC,BB,AA; data_rvalid at cycle 10; instr_rvalid stays 0.
- **Simultaneous requests with StarveLimit=4:** both reqs held high continuously → grant order D,D,D,D,I,D,D,D,D,I; never both gnts in one cycle.
- **Backpressure:** ready toggles 1,0,0,1,… → each byte held stable while stalled; no beat dropped or duplicated; rvalid delayed by exactly the number of stall cycles.
- **Read error:** `pad_in_err_i` high on byte 2 → rvalid with err=1 and rdata still assembled.
- **Reset mid-ADDR (after beat 1):** rst_ni pulsed low → all outputs 0 immediately; no rvalid; a fresh request after release starts with the header byte.
